// File: rtl/pulse_pacer_pkg.sv
// pulse_pacer_pkg: shared definitions for the pulse pacer / stretcher family.
//   pacer_state_e : FSM encoding (IDLE=0, PULSE=1, GAP=2)
//   timer_width() : width of a down-counter that must hold max(pulse_width, gap)
package pulse_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } pacer_state_e;

  function automatic int unsigned timer_width(input int unsigned pulse_width,
                                              input int unsigned gap);
    int unsigned longest;
    longest = (pulse_width > gap) ? pulse_width : gap;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pulse_pacer_sat_counter.sv
// sat_counter: up/down counter that saturates at both ends.
//   clk, reset : clock, synchronous active-high reset
//   inc, dec   : count up / down; both together leave the count unchanged
//   count      : current value
//   ovf        : strobe, high when inc alone is requested while the count is full
module sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    if (inc && !dec) begin
      if (count_q == '1) begin
        ovf = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pulse_pacer.sv
// pulse_pacer: converts rising edges on `in` into single PULSE_WIDTH-wide
// pulses separated by at least GAP low cycles; surplus events are held in a
// saturating backlog and replayed.
//   clk, reset : clock, synchronous active-high reset
//   in         : event line, each 0->1 transition is one event
//   ovf_clr    : clears the sticky overflow flag (a same-cycle overflow wins)
//   out        : paced pulse, registered
//   pending    : backlog of events not yet dispatched
//   overflow   : sticky, set when an event is dropped on a full backlog
//   busy       : FSM not idle or backlog non-empty
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = 1,
  parameter int unsigned GAP         = 4,
  parameter int unsigned DEPTH_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  input  logic                  ovf_clr,
  output logic                  out,
  output logic [DEPTH_BITS-1:0] pending,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned TW = timer_width(PULSE_WIDTH, GAP);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP - 1);

  pacer_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          in_q, in_d;
  logic          out_q, out_d;
  logic          overflow_q, overflow_d;

  logic ev;
  logic dispatch;
  logic deq;
  logic enq;
  logic sat_ovf;

  sat_counter #(
    .WIDTH(DEPTH_BITS)
  ) u_backlog (
    .clk   (clk),
    .reset (reset),
    .inc   (enq),
    .dec   (deq),
    .count (pending),
    .ovf   (sat_ovf)
  );

  always_comb begin
    in_d     = in;
    ev       = in & ~in_q;
    dispatch = (state_q == ST_IDLE) && (ev || (pending != '0));
    // Queue is served first; a same-edge event is then queued instead.
    deq      = dispatch && (pending != '0);
    enq      = ev && !(dispatch && !deq);

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (dispatch) begin
          state_d = ST_PULSE;
          timer_d = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Registered from the next state so `out` has no path from `in`.
    out_d = (state_d == ST_PULSE);

    if (sat_ovf) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      in_q       <= 1'b0;
      out_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      in_q       <= in_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_pacer.sv
module tb_pulse_pacer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, din, clr;
  logic       out0, ovf0, busy0;
  logic       out1, ovf1, busy1;
  logic       out2, ovf2, busy2;
  logic [3:0] pend0;
  logic [1:0] pend1;
  logic [3:0] pend2;

  pulse_pacer #(.PULSE_WIDTH(1), .GAP(4), .DEPTH_BITS(4)) u_dut0 (
    .clk(clk), .reset(rst[0]), .in(din[0]), .ovf_clr(clr[0]),
    .out(out0), .pending(pend0), .overflow(ovf0), .busy(busy0));

  pulse_pacer #(.PULSE_WIDTH(1), .GAP(8), .DEPTH_BITS(2)) u_dut1 (
    .clk(clk), .reset(rst[1]), .in(din[1]), .ovf_clr(clr[1]),
    .out(out1), .pending(pend1), .overflow(ovf1), .busy(busy1));

  pulse_pacer #(.PULSE_WIDTH(3), .GAP(2), .DEPTH_BITS(4)) u_dut2 (
    .clk(clk), .reset(rst[2]), .in(din[2]), .ovf_clr(clr[2]),
    .out(out2), .pending(pend2), .overflow(ovf2), .busy(busy2));

  typedef struct {
    int   dut;
    int   c;
    logic o;
    int   p;
    logic ov;
    logic b;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: dispatch allowed once the cycle reaches m_next.
  int m_pw[3]  = '{1, 1, 3};
  int m_gap[3] = '{4, 8, 2};
  int m_max[3] = '{15, 3, 15};
  int m_next[3];
  int m_disp[3];
  int m_pend[3];
  bit m_ovf[3];
  bit m_inp[3];

  int   rises[3][$];
  int   falls[3][$];
  logic prev_out[3];
  logic prev_busy0;
  int   bfall0;
  int   pmax[3];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_step(input int i);
    int   c;
    bit   ev;
    bit   nov;
    exp_t e;
    c   = cyc;
    nov = 1'b0;
    if (rst[i]) begin
      m_pend[i] = 0;
      m_ovf[i]  = 1'b0;
      m_inp[i]  = 1'b0;
      m_next[i] = c + 1;
      m_disp[i] = -100;
    end else begin
      ev       = din[i] && !m_inp[i];
      m_inp[i] = din[i];
      if (c >= m_next[i] && (ev || m_pend[i] > 0)) begin
        m_disp[i] = c;
        m_next[i] = c + m_pw[i] + m_gap[i] + 1;
        if (m_pend[i] > 0) begin
          m_pend[i]--;
          if (ev) m_pend[i]++;
        end
      end else if (ev) begin
        if (m_pend[i] == m_max[i]) nov = 1'b1;
        else m_pend[i]++;
      end
      if (nov) m_ovf[i] = 1'b1;
      else if (clr[i]) m_ovf[i] = 1'b0;
    end
    e.dut = i;
    e.c   = c;
    e.o   = (c >= m_disp[i]) && (c < m_disp[i] + m_pw[i]);
    e.p   = m_pend[i];
    e.ov  = m_ovf[i];
    e.b   = (c < m_next[i] - 1) || (m_pend[i] != 0);
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic o, ov, b;
    int   p;
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin o = out0; p = int'(pend0); ov = ovf0; b = busy0; end
        1:       begin o = out1; p = int'(pend1); ov = ovf1; b = busy1; end
        default: begin o = out2; p = int'(pend2); ov = ovf2; b = busy2; end
      endcase
      check_eq($sformatf("d%0d out@%0d", e.dut, e.c), o, e.o);
      check_eq($sformatf("d%0d pending@%0d", e.dut, e.c), p, e.p);
      check_eq($sformatf("d%0d overflow@%0d", e.dut, e.c), ov, e.ov);
      check_eq($sformatf("d%0d busy@%0d", e.dut, e.c), b, e.b);
      if (o && !prev_out[e.dut]) rises[e.dut].push_back(cyc - 1);
      if (!o && prev_out[e.dut]) falls[e.dut].push_back(cyc - 1);
      prev_out[e.dut] = o;
      if (p > pmax[e.dut]) pmax[e.dut] = p;
    end
    if (prev_busy0 && !busy0) bfall0 = cyc - 1;
    prev_busy0 = busy0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      rises[i].delete();
      falls[i].delete();
      pmax[i] = 0;
    end
    bfall0 = -1;
  endtask

  int s;

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_next[i] = 0; m_disp[i] = -100; m_pend[i] = 0;
      m_ovf[i] = 1'b0; m_inp[i] = 1'b0; prev_out[i] = 1'b0;
    end
    prev_busy0 = 1'b0;
    rst = '1; din = '0; clr = '0;
    repeat (3) tick();
    check_eq("reset out", out0, 0);
    check_eq("reset pending", pend0, 0);
    check_eq("reset overflow", ovf0, 0);
    check_eq("reset busy", busy0, 0);
    rst = '0;
    repeat (2) tick();

    // Single held-high edge.
    clear_logs();
    s = cyc;
    din[0] = 1'b1;
    repeat (20) tick();
    din[0] = 1'b0;
    repeat (10) tick();
    check_eq("single pulse count", rises[0].size(), 1);
    if (rises[0].size() > 0) check_eq("single rise cycle", rises[0][0], s);
    check_eq("single pending peak", pmax[0], 0);

    // Burst of three edges.
    clear_logs();
    s = cyc;
    for (int k = 0; k < 5; k++) begin
      din[0] = (k % 2 == 0);
      tick();
    end
    din[0] = 1'b0;
    repeat (25) tick();
    check_eq("burst pulse count", rises[0].size(), 3);
    if (rises[0].size() == 3) begin
      check_eq("burst rise0", rises[0][0], s);
      check_eq("burst rise1", rises[0][1], s + 6);
      check_eq("burst rise2", rises[0][2], s + 12);
    end
    check_eq("burst pending peak", pmax[0], 2);
    check_eq("burst busy fall", bfall0, s + 17);

    // Queue dispatch coinciding with a new edge.
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      din[0] = (k == 0 || k == 2 || k == 6);
      tick();
      if (k == 6) begin
        check_eq("simul pending", pend0, 1);
        check_eq("simul out", out0, 1);
      end
    end
    din[0] = 1'b0;
    repeat (20) tick();

    // Reset during PULSE with backlog of 3.
    clear_logs();
    for (int k = 0; k < 13; k++) begin
      din[0] = (k <= 10) && (k % 2 == 0);
      tick();
    end
    check_eq("pre-reset pending", pend0, 3);
    check_eq("pre-reset out", out0, 1);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check_eq("post-reset out", out0, 0);
    check_eq("post-reset pending", pend0, 0);
    check_eq("post-reset busy", busy0, 0);
    check_eq("post-reset overflow", ovf0, 0);
    din[0] = 1'b1;
    tick();
    check_eq("post-reset dispatch", out0, 1);
    din[0] = 1'b0;
    repeat (10) tick();

    // Overflow on a 2-bit backlog.
    clear_logs();
    s = cyc;
    for (int k = 0; k < 10; k++) begin
      din[1] = (k <= 8) && (k % 2 == 0);
      tick();
      if (k == 6) check_eq("ovf pending full", pend1, 3);
      if (k == 8) begin
        check_eq("ovf flag set", ovf1, 1);
        check_eq("ovf pending held", pend1, 3);
      end
    end
    din[1] = 1'b0;
    repeat (40) tick();
    check_eq("ovf pulse count", rises[1].size(), 4);
    if (rises[1].size() > 1) check_eq("ovf second rise", rises[1][1], s + 10);
    check_eq("ovf still set", ovf1, 1);
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    check_eq("ovf cleared", ovf1, 0);

    // PULSE_WIDTH=3, GAP=2 sustained backlog.
    clear_logs();
    s = cyc;
    for (int k = 0; k < 16; k++) begin
      din[2] = (k % 2 == 0);
      tick();
    end
    din[2] = 1'b0;
    repeat (60) tick();
    check_eq("pw3 pulse count", rises[2].size(), 8);
    check_eq("pw3 fall count", falls[2].size(), 8);
    if (rises[2].size() == 8 && falls[2].size() == 8) begin
      check_eq("pw3 first rise", rises[2][0], s);
      for (int k = 0; k < 8; k++) begin
        check_eq($sformatf("pw3 width%0d", k), falls[2][k] - rises[2][k], 3);
        if (k > 0) check_eq($sformatf("pw3 spacing%0d", k), rises[2][k] - rises[2][k-1], 6);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
